// File: rtl/gb_pkg.sv
// Shared helpers for the lane gearbox: width math, interleave bit map, slice index
// and parameter legality checks.
package gb_pkg;

   function automatic int unsigned gear(input int unsigned in_w, input int unsigned out_w);
      return in_w / out_w;
   endfunction

   function automatic int unsigned lvl_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Phase register width; kept at 1 bit when GEAR == 1 so the vector never collapses.
   function automatic int unsigned ph_w(input int unsigned g);
      return (g > 1) ? $clog2(g) : 1;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_ok(input int unsigned lanes, input int unsigned in_w,
                                    input int unsigned out_w, input int unsigned depth,
                                    input int unsigned prefill);
      return (lanes >= 1) && (lanes <= 8) && (out_w >= 1) && (in_w % out_w == 0) &&
             is_pow2(in_w / out_w) && (depth >= 2) && is_pow2(depth) &&
             (prefill >= 1) && (prefill <= depth);
   endfunction

   // Interleave as a bit map: interleaved bit idx takes in_data bit il_src(idx).
   function automatic int unsigned il_src(input int unsigned idx, input int unsigned lanes,
                                          input int unsigned in_w);
      return in_w * (idx % lanes) + (idx / lanes);
   endfunction

   function automatic int unsigned slice_idx(input int unsigned phase, input int unsigned g,
                                             input bit msb_first);
      return msb_first ? (g - 1 - phase) : phase;
   endfunction

endpackage

// File: rtl/gb_sync_fifo.sv
// Single-clock FIFO of interleaved words with show-ahead read and synchronous flush.
module gb_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned LVL_W = 4
) (
   input  logic             clk_s,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push, do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem[rd_ptr_q];
   // A pop never frees room for a same-cycle push.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk_s) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk_s or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      level_q <= level_q + 1'b1;
         else if (do_pop && !do_push) level_q <= level_q - 1'b1;
      end
   end

endmodule

// File: rtl/tx_lane_gearbox.sv
// Lane-interleaving transmit gearbox: buffers LANES*IN_W words and emits LANES*OUT_W
// slices per read, with prefill-gated tx_ready and sticky error flags.
module tx_lane_gearbox
   import gb_pkg::*;
#(
   parameter int unsigned LANES           = 4,
   parameter int unsigned IN_W            = 8,
   parameter int unsigned OUT_W           = 4,
   parameter int unsigned DEPTH           = 8,
   parameter int unsigned PREFILL         = 2,
   parameter int unsigned MSB_SLICE_FIRST = 0
) (
   input  logic                          clk_s,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          hsxx_clk_en,
   input  logic [LANES*IN_W-1:0]         in_data,
   output logic                          in_ready,
   input  logic                          out_rd,
   output logic [LANES*OUT_W-1:0]        out_data,
   output logic                          out_valid,
   output logic                          tx_ready,
   output logic [$clog2(DEPTH+1)-1:0]    level,
   output logic                          overflow,
   output logic                          underflow
);
   localparam int unsigned GEAR  = gear(IN_W, OUT_W);
   localparam int unsigned LVL_W = lvl_w(DEPTH);
   localparam int unsigned PH_W  = ph_w(GEAR);
   localparam int unsigned W_IN  = LANES * IN_W;
   localparam int unsigned W_OUT = LANES * OUT_W;

   if (!params_ok(LANES, IN_W, OUT_W, DEPTH, PREFILL)) begin : g_bad_params
      $error("tx_lane_gearbox: illegal parameter combination");
   end

   logic [W_IN-1:0]  wr_word, head;
   logic [W_OUT-1:0] slices [2**PH_W];
   logic [PH_W-1:0]  phase_q, phase_d, sel;
   logic [LVL_W-1:0] level_nxt;
   logic             full, empty, wr_acc, rd_acc, last, pop;
   logic             tx_ready_q, tx_ready_d, overflow_q, overflow_d, underflow_q, underflow_d;

   for (genvar i = 0; i < W_IN; i++) begin : g_il
      assign wr_word[i] = in_data[il_src(i, LANES, IN_W)];
   end

   for (genvar s = 0; s < 2**PH_W; s++) begin : g_slice
      if (s < GEAR) begin : g_real
         assign slices[s] = head[s*W_OUT +: W_OUT];
      end else begin : g_pad
         assign slices[s] = '0;
      end
   end

   gb_sync_fifo #(
      .WIDTH (W_IN),
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk_s (clk_s),
      .reset (reset),
      .flush (flush),
      .push  (wr_acc),
      .pop   (pop),
      .wdata (wr_word),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign wr_acc    = hsxx_clk_en && !full && !flush;
   assign rd_acc    = out_rd && !empty && !flush;
   assign last      = (phase_q == PH_W'(GEAR - 1));
   assign pop       = rd_acc && last;
   assign sel       = PH_W'(slice_idx(32'(phase_q), GEAR, MSB_SLICE_FIRST != 0));
   assign out_data  = empty ? '0 : slices[sel];
   assign tx_ready  = tx_ready_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   always_comb begin
      level_nxt   = level;
      phase_d     = phase_q;
      tx_ready_d  = tx_ready_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (wr_acc && !pop)      level_nxt = level + 1'b1;
      else if (pop && !wr_acc) level_nxt = level - 1'b1;
      if (flush) begin
         phase_d     = '0;
         tx_ready_d  = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (rd_acc) phase_d = last ? '0 : phase_q + 1'b1;
         if (32'(level_nxt) >= PREFILL) tx_ready_d = 1'b1;
         if (hsxx_clk_en && full) overflow_d = 1'b1;
         if (out_rd && empty && tx_ready_q) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_s or posedge reset) begin
      if (reset) begin
         phase_q     <= '0;
         tx_ready_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         tx_ready_q  <= tx_ready_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_tx_lane_gearbox.sv
// Directed scoreboard bench for tx_lane_gearbox; a second instance checks MSB-first order.
module tb_tx_lane_gearbox;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned PREFILL = 2;

   logic        clk_s = 1'b0;
   logic        reset, flush, hsxx_clk_en, out_rd;
   logic [31:0] in_data;
   logic        in_ready, out_valid, tx_ready, overflow, underflow;
   logic [15:0] out_data;
   logic [3:0]  level;
   logic        in_ready1, out_valid1, tx_ready1, overflow1, underflow1;
   logic [15:0] out_data1;
   logic [3:0]  level1;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sb0[$];
   logic [15:0] sb1[$];
   int          mcnt = 0;
   int          mph = 0;
   bit          mtx = 0, mov = 0, mun = 0;

   always #5 clk_s = ~clk_s;

   tx_lane_gearbox #(.LANES(4), .IN_W(8), .OUT_W(4), .DEPTH(DEPTH), .PREFILL(PREFILL),
                     .MSB_SLICE_FIRST(0)) dut (
      .clk_s(clk_s), .reset(reset), .flush(flush), .hsxx_clk_en(hsxx_clk_en),
      .in_data(in_data), .in_ready(in_ready), .out_rd(out_rd), .out_data(out_data),
      .out_valid(out_valid), .tx_ready(tx_ready), .level(level), .overflow(overflow),
      .underflow(underflow));

   tx_lane_gearbox #(.LANES(4), .IN_W(8), .OUT_W(4), .DEPTH(DEPTH), .PREFILL(PREFILL),
                     .MSB_SLICE_FIRST(1)) dut_msb (
      .clk_s(clk_s), .reset(reset), .flush(flush), .hsxx_clk_en(hsxx_clk_en),
      .in_data(in_data), .in_ready(in_ready1), .out_rd(out_rd), .out_data(out_data1),
      .out_valid(out_valid1), .tx_ready(tx_ready1), .level(level1), .overflow(overflow1),
      .underflow(underflow1));

   function automatic logic [31:0] il_model(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int l = 0; l < 4; l++)
         for (int b = 0; b < 8; b++) r[4*b+l] = w[8*l+b];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_s);
      #1;
   endtask

   task automatic model_push(input logic [31:0] w);
      logic [31:0] il;
      il = il_model(w);
      if (mcnt < DEPTH) begin
         sb0.push_back(il[15:0]);
         sb0.push_back(il[31:16]);
         sb1.push_back(il[31:16]);
         sb1.push_back(il[15:0]);
         mcnt++;
         if (mcnt >= PREFILL) mtx = 1;
      end else begin
         mov = 1;
      end
   endtask

   // Compares the show-ahead slice before the read edge, then advances the model.
   task automatic model_read();
      chk("rd_valid", {31'b0, out_valid}, {31'b0, mcnt > 0});
      if (mcnt > 0) begin
         if (sb0.size() == 0 || sb1.size() == 0) begin
            chk("sb_underrun", 32'd0, 32'd1);
         end else begin
            chk("slice_lsb_first", {16'b0, out_data}, {16'b0, sb0.pop_front()});
            chk("slice_msb_first", {16'b0, out_data1}, {16'b0, sb1.pop_front()});
         end
         if (mph == 1) begin
            mph = 0;
            mcnt--;
         end else begin
            mph = 1;
         end
      end else if (mtx) begin
         mun = 1;
      end
   endtask

   task automatic model_flush();
      sb0.delete();
      sb1.delete();
      mcnt = 0;
      mph  = 0;
      mtx  = 0;
      mov  = 0;
      mun  = 0;
   endtask

   task automatic wr(input logic [31:0] w);
      in_data     = w;
      hsxx_clk_en = 1'b1;
      model_push(w);
      cyc();
      hsxx_clk_en = 1'b0;
   endtask

   task automatic rd();
      model_read();
      out_rd = 1'b1;
      cyc();
      out_rd = 1'b0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_level"}, {28'b0, level}, 32'(mcnt));
      chk({tag, "_out_valid"}, {31'b0, out_valid}, {31'b0, mcnt > 0});
      chk({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, mcnt < DEPTH});
      chk({tag, "_tx_ready"}, {31'b0, tx_ready}, {31'b0, mtx});
      chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, mov});
      chk({tag, "_underflow"}, {31'b0, underflow}, {31'b0, mun});
      if (mcnt == 0) chk({tag, "_idle_data"}, {16'b0, out_data}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; hsxx_clk_en = 1'b0; out_rd = 1'b0; in_data = '0;
      #12;
      reset = 1'b0;
      cyc();
      chk_state("reset");

      // Interleave of one bit per lane.
      wr(32'h8040_2010);
      chk_state("il_write");
      rd();
      chk_state("il_mid");
      rd();
      chk_state("il_drained");

      // Lane 0 all ones.
      wr(32'h0000_00FF);
      rd();
      chk_state("pat_mid");
      rd();
      chk_state("pat_drained");

      // Prefill gating, then drain and underflow.
      wr(32'h1234_5678);
      chk_state("pre_one");
      wr(32'h9ABC_DEF0);
      chk_state("pre_two");
      for (int i = 0; i < 4; i++) rd();
      chk_state("pre_drained");
      rd();
      chk_state("underflow");
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      model_flush();
      chk_state("flush_flags");

      // Fill past full.
      for (int i = 0; i < 9; i++) begin
         wr($urandom);
         if (i == 7) chk_state("full8");
      end
      chk_state("overflow9");
      rd();
      // Pop and write together at full: write is still dropped.
      in_data     = 32'hDEAD_BEEF;
      hsxx_clk_en = 1'b1;
      model_push(32'hDEAD_BEEF);
      model_read();
      out_rd      = 1'b1;
      cyc();
      hsxx_clk_en = 1'b0;
      out_rd      = 1'b0;
      chk_state("concur_full");
      for (int i = 0; i < 14; i++) rd();
      chk_state("full_drained");

      // Flush mid-word with a write presented.
      wr(32'hA5A5_0F0F);
      wr(32'h0123_4567);
      rd();
      flush       = 1'b1;
      hsxx_clk_en = 1'b1;
      in_data     = 32'hFFFF_FFFF;
      cyc();
      flush       = 1'b0;
      hsxx_clk_en = 1'b0;
      model_flush();
      chk_state("flush_mid");
      wr(32'hC3C3_3C3C);
      rd();
      rd();
      chk_state("post_flush");

      // Asynchronous reset off the clock edge.
      wr(32'h5555_AAAA);
      wr(32'h0F0F_F0F0);
      rd();
      #3;
      reset = 1'b1;
      #1;
      model_flush();
      chk_state("async_reset");
      reset = 1'b0;
      cyc();
      wr(32'h7E81_18E7);
      rd();
      rd();
      chk_state("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_lane_gearbox.md
Name: tx_lane_gearbox

Overview:
Parametrised successor of the 4-lane x4 transmit gearing path. Accepts per-lane parallel words on clk_s, bit-interleaves them lane-wise, and buffers them in a DEPTH-word FIFO. Emits LANES*OUT_W-bit slices, one per accepted read, to the downstream DDR serializer feed. Adds behaviour the fixed 32->16 path lacks:
- generic lane count and gear ratio
- prefill-gated tx_ready
- sticky overflow/underflow flags
- synchronous flush
- selectable slice order

Parameters:
LANES, 4, number of serial lanes (1..8)
IN_W, 8, bits per lane per input word
OUT_W, 4, bits per lane per output slice; IN_W/OUT_W = GEAR, power of 2, >=1
DEPTH, 8, FIFO depth in input words, power of 2, >=2
PREFILL, 2, words required in FIFO before tx_ready first asserts (1..DEPTH)
MSB_SLICE_FIRST, 0, 0: slice 0 (lowest interleaved bits) sent first; 1: highest first

Ports:
clk_s  in  1  system byte clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of FIFO, phase, flags, tx_ready
hsxx_clk_en  in  1  write strobe: in_data valid this cycle
in_data  in  LANES*IN_W  lane l occupies bits [IN_W*l+IN_W-1 : IN_W*l]
in_ready  out  1  FIFO not full
out_rd  in  1  consumer takes current slice this cycle
out_data  out  LANES*OUT_W  current head slice (show-ahead)
out_valid  out  1  FIFO holds >=1 word
tx_ready  out  1  prefill reached; stays high until flush/reset
level  out  $clog2(DEPTH+1)  words stored, including the partially read head
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: out_rd while !out_valid and tx_ready=1

Behaviour:
- Reset (async, active-high): pointers, level, phase = 0; in_ready=1; out_valid=0; out_data=0; tx_ready=0; overflow=0; underflow=0.
- Interleave on write: stored bit I[LANES*b+l] = in_data[IN_W*l+b], for b<IN_W, l<LANES.
- Slice s (0..GEAR-1) = I[LANES*OUT_W*(s+1)-1 : LANES*OUT_W*s].
- Emitted slice index: phase if MSB_SLICE_FIRST=0, else GEAR-1-phase.
- Write: hsxx_clk_en && !full stores the word. Word appears at head (out_valid=1) the cycle after the write edge when the FIFO was empty; level increments at that same edge.
- Write while full: word dropped, state unchanged, overflow<=1. A pop in the same cycle does not rescue it, so in_ready is purely !full.
- Read: out_rd && out_valid advances phase. On phase==GEAR-1 the phase wraps to 0, the head pops and level decrements. GEAR=1 pops every read.
- Simultaneous push and pop: level unchanged. Pointers wrap modulo DEPTH.
- out_valid=0: out_data=0 (idle pattern). out_rd is ignored except for flag update: underflow<=1 if tx_ready=1.
- tx_ready: set on the edge where level becomes >=PREFILL. Never cleared by draining; cleared only by flush/reset.
- flush: has priority over hsxx_clk_en and out_rd in the same cycle. Next cycle equals the reset state; a write presented during flush is discarded and does not set overflow.
- Reset asserted mid-transfer: immediate clear; partial head word is lost.
- Latency: write edge to first slice visible = 1 cycle; consecutive slices every cycle while out_rd=1.

Decomposition:
- Package gb_pkg holds:
  - GEAR and level-width localparam helpers
  - interleave function (word -> interleaved vector)
  - slice-select function
  - elaboration checks (IN_W % OUT_W == 0, GEAR power of 2, DEPTH power of 2)
- Sub-module gb_sync_fifo: single-clock FIFO with push/pop/full/empty/level and async reset. It stores interleaved words only; phase, slicing, tx_ready and flags live in tx_lane_gearbox.

Test Plan:
- Interleave: LANES=4, IN_W=8, OUT_W=4. Write 0x80402010, then out_rd twice -> slices 0x0000 then 0x8421. With MSB_SLICE_FIRST=1 -> 0x8421 then 0x0000.
- Pattern: write 0x000000FF -> slices 0x1111, 0x1111; level 1->0 on the second read edge; out_valid drops and out_data=0.
- Prefill: PREFILL=2. One write -> tx_ready=0. Second write -> tx_ready=1 at that edge. Drain fully -> tx_ready stays 1. One more out_rd -> underflow=1.
- Full/overflow: DEPTH=8. Write 9 words with no reads -> in_ready=0 after the 8th, overflow=1 after the 9th, level=8. Read 16 slices -> words 1..8 intact in order; word 9 absent.
- Concurrency at full: level=8, hsxx_clk_en=1 and out_rd=1 at phase 1 -> pop occurs, write dropped, level=7, overflow=1.
- Flush/reset mid-word: after 1 of 2 slices read, assert flush together with hsxx_clk_en -> next cycle level=0, phase=0, flags=0, tx_ready=0, no write stored. Repeat with async reset pulsed off-edge -> outputs clear immediately.
